writeback_unit: RTL and testbench

- Writer side of the integer register file: the final pipeline stage that produces the rd write port.
- Accepts retiring instructions from the MEM stage over a valid/ready handshake.
- For loads, waits for the data-memory response, then byte-selects and sign- or zero-extends the data.
- Drives the registered write triple (rd address, rd data, write enable) into the register file.

---
 rtl/writeback_unit.sv | 132 +++++++++++++
 tb/tb_writeback_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file writer stage: retires ALU results in one cycle, waits for load data,
// then byte-selects and extends it. Optional load timeout under `WB_LD_TIMEOUT_EN`.
module writeback_unit #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [4:0]        i_rd_addr,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic              i_regWrite,
  input  logic              i_memToReg,
  input  logic [2:0]        i_funct3,
  input  logic [2:0]        i_byte_off,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic [4:0]        o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_regWrite,
  output logic              o_busy,
  output logic              o_timeout,
  output logic [0:0]        o_dbg_state
);

  // Handshake: an instruction transfers on a rising edge where i_valid && o_ready;
  // o_ready is high only in IDLE and never depends on i_valid.

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  if (DATA_W != 64 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("writeback_unit: DATA_W must be 64 and TIMEOUT_CYC at least 1");
  end

  logic [0:0]        state;
  logic [4:0]        ld_rd;
  logic              ld_we;
  logic [2:0]        ld_f3;
  logic [2:0]        ld_off;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_data;

  assign o_ready     = (state == S_IDLE);
  assign o_busy      = (state == S_WAIT_MEM);
  assign o_dbg_state = state;

  // Misaligned loads simply see zeros shifted into the upper bytes.
  always_comb begin
    shifted = i_mem_rdata >> {ld_off, 3'b000};
    case (ld_f3)
      3'b000:  ld_data = {{56{shifted[7]}},  shifted[7:0]};
      3'b001:  ld_data = {{48{shifted[15]}}, shifted[15:0]};
      3'b010:  ld_data = {{32{shifted[31]}}, shifted[31:0]};
      3'b100:  ld_data = {56'd0, shifted[7:0]};
      3'b101:  ld_data = {48'd0, shifted[15:0]};
      3'b110:  ld_data = {32'd0, shifted[31:0]};
      default: ld_data = shifted;
    endcase
  end

`ifdef WB_LD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      ld_rd      <= '0;
      ld_we      <= 1'b0;
      ld_f3      <= '0;
      ld_off     <= '0;
      o_rd_addr  <= '0;
      o_rd_data  <= '0;
      o_regWrite <= 1'b0;
`ifdef WB_LD_TIMEOUT_EN
      wait_cnt   <= '0;
      o_timeout  <= 1'b0;
`endif
    end else begin
      o_regWrite <= 1'b0;
`ifdef WB_LD_TIMEOUT_EN
      o_timeout  <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            if (i_memToReg) begin
              ld_rd  <= i_rd_addr;
              ld_we  <= i_regWrite;
              ld_f3  <= i_funct3;
              ld_off <= i_byte_off;
              state  <= S_WAIT_MEM;
`ifdef WB_LD_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else if (i_regWrite && (i_rd_addr != 5'd0)) begin
              o_rd_addr  <= i_rd_addr;
              o_rd_data  <= i_alu_result;
              o_regWrite <= 1'b1;
            end
          end
        end
        S_WAIT_MEM: begin
          if (i_mem_rvalid) begin
            state <= S_IDLE;
            if (ld_we && (ld_rd != 5'd0)) begin
              o_rd_addr  <= ld_rd;
              o_rd_data  <= ld_data;
              o_regWrite <= 1'b1;
            end
`ifdef WB_LD_TIMEOUT_EN
          end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            state     <= S_IDLE;
            o_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef WB_LD_TIMEOUT_EN
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed, table-driven bench for writeback_unit with a write scoreboard.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [4:0]  rd_addr_in;
  logic [63:0] alu;
  logic        reg_write_in;
  logic        mem_to_reg;
  logic [2:0]  funct3;
  logic [2:0]  byte_off;
  logic        rvalid;
  logic [63:0] rdata;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        reg_write;
  logic        busy;
  logic        timeout;
  logic [0:0]  dbg_state;

  int checks = 0;
  int passed = 0;
  int wr_pulses = 0;
  int ready_low = 0;

  logic [68:0] exp_q[$];
  logic [4:0]  model_addr = '0;
  logic [63:0] model_data = '0;

  writeback_unit dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_rd_addr(rd_addr_in), .i_alu_result(alu), .i_regWrite(reg_write_in),
    .i_memToReg(mem_to_reg), .i_funct3(funct3), .i_byte_off(byte_off),
    .i_mem_rvalid(rvalid), .i_mem_rdata(rdata), .o_rd_addr(rd_addr),
    .o_rd_data(rd_data), .o_regWrite(reg_write), .o_busy(busy),
    .o_timeout(timeout), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (!ready) ready_low++;
      if (reg_write === 1'b1) begin
        wr_pulses++;
        if (exp_q.size() == 0) check("unexpected_write", {59'd0, rd_addr}, 64'd0);
        else begin
          logic [68:0] e;
          e = exp_q.pop_front();
          check("sb_addr", {59'd0, rd_addr}, {59'd0, e[68:64]});
          check("sb_data", rd_data, e[63:0]);
        end
      end
    end
  end

  task automatic idle_inputs();
    valid = 1'b0; rd_addr_in = '0; alu = '0; reg_write_in = 1'b0;
    mem_to_reg = 1'b0; funct3 = '0; byte_off = '0; rvalid = 1'b0; rdata = '0;
  endtask

  task automatic drive_op(input logic ld, input logic [4:0] rd, input logic [63:0] a,
                          input logic we, input logic [2:0] f3, input logic [2:0] off);
    valid = 1'b1; mem_to_reg = ld; rd_addr_in = rd; alu = a;
    reg_write_in = we; funct3 = f3; byte_off = off;
  endtask

  task automatic expect_write(input logic we, input logic [4:0] rd, input logic [63:0] d);
    if (we) begin
      exp_q.push_back({rd, d});
      model_addr = rd;
      model_data = d;
    end
  endtask

  task automatic check_out(input string tag, input logic we);
    check({tag, "_we"},   {63'd0, reg_write}, {63'd0, we});
    check({tag, "_addr"}, {59'd0, rd_addr}, {59'd0, model_addr});
    check({tag, "_data"}, rd_data, model_data);
  endtask

  typedef struct {
    logic        is_ld;
    logic [4:0]  rd;
    logic [63:0] alu;
    logic        we;
    logic [2:0]  f3;
    logic [2:0]  off;
    logic [63:0] rdata;
    logic        exp_we;
    logic [63:0] exp_data;
  } vec_t;

  localparam logic [63:0] R = 64'hFEDC_BA98_7654_3210;
  vec_t vecs[14];

  initial begin
    vecs[0]  = '{1'b0, 5'd5,  64'h1234, 1'b1, 3'b000, 3'd0, 64'd0, 1'b1, 64'h1234};
    vecs[1]  = '{1'b1, 5'd7,  64'h0, 1'b1, 3'b000, 3'd3, 64'h0000_0000_80FF_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[2]  = '{1'b1, 5'd8,  64'h0, 1'b1, 3'b101, 3'd2, R, 1'b1, 64'h7654};
    vecs[3]  = '{1'b1, 5'd9,  64'h0, 1'b1, 3'b110, 3'd4, R, 1'b1, 64'hFEDC_BA98};
    vecs[4]  = '{1'b1, 5'd10, 64'h0, 1'b1, 3'b011, 3'd0, R, 1'b1, R};
    vecs[5]  = '{1'b1, 5'd11, 64'h0, 1'b1, 3'b010, 3'd4, R, 1'b1, 64'hFFFF_FFFF_FEDC_BA98};
    vecs[6]  = '{1'b1, 5'd12, 64'h0, 1'b1, 3'b001, 3'd6, R, 1'b1, 64'hFFFF_FFFF_FFFF_FEDC};
    vecs[7]  = '{1'b1, 5'd13, 64'h0, 1'b1, 3'b010, 3'd6, R, 1'b1, 64'h0000_FEDC};
    vecs[8]  = '{1'b1, 5'd14, 64'h0, 1'b1, 3'b111, 3'd1, R, 1'b1, 64'h00FE_DCBA_9876_5432};
    vecs[9]  = '{1'b1, 5'd15, 64'h0, 1'b1, 3'b100, 3'd7, R, 1'b1, 64'hFE};
    vecs[10] = '{1'b1, 5'd0,  64'h0, 1'b1, 3'b011, 3'd0, R, 1'b0, 64'h0};
    vecs[11] = '{1'b0, 5'd3,  64'hDEAD, 1'b0, 3'b000, 3'd0, 64'd0, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 5'd0,  64'hBEEF, 1'b1, 3'b000, 3'd0, 64'd0, 1'b0, 64'h0};
    vecs[13] = '{1'b1, 5'd16, 64'h0, 1'b1, 3'b000, 3'd0, R, 1'b1, 64'h10};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    check_out("rst", 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive_op(vecs[i].is_ld, vecs[i].rd, vecs[i].alu, vecs[i].we, vecs[i].f3, vecs[i].off);
      if (!vecs[i].is_ld) expect_write(vecs[i].exp_we, vecs[i].rd, vecs[i].exp_data);
      @(negedge clk);
      idle_inputs();
      if (vecs[i].is_ld) begin
        check("ld_accept_we", {63'd0, reg_write}, 64'd0);
        for (int k = 0; k < 2; k++) begin
          check("ld_busy", {63'd0, busy}, 64'd1);
          check("ld_ready", {63'd0, ready}, 64'd0);
          @(negedge clk);
        end
        rvalid = 1'b1;
        rdata = vecs[i].rdata;
        expect_write(vecs[i].exp_we, vecs[i].rd, vecs[i].exp_data);
        @(negedge clk);
        idle_inputs();
        check_out($sformatf("ld%0d", i), vecs[i].exp_we);
        check("ld_done_ready", {63'd0, ready}, 64'd1);
        check("ld_done_busy", {63'd0, busy}, 64'd0);
      end else begin
        check_out($sformatf("alu%0d", i), vecs[i].exp_we);
        @(negedge clk);
        check("alu_we_drop", {63'd0, reg_write}, 64'd0);
      end
    end

    // Three back-to-back ALU ops, then a load answered 4 cycles after accept.
    begin
      int w0, r0;
      @(negedge clk);
      w0 = wr_pulses; r0 = ready_low;
      for (int j = 0; j < 3; j++) begin
        drive_op(1'b0, 5'(20 + j), 64'h100 + 64'(j), 1'b1, 3'b000, 3'd0);
        expect_write(1'b1, 5'(20 + j), 64'h100 + 64'(j));
        @(negedge clk);
      end
      drive_op(1'b1, 5'd25, 64'h0, 1'b1, 3'b011, 3'd0);
      @(negedge clk);
      idle_inputs();
      repeat (3) @(negedge clk);
      rvalid = 1'b1; rdata = 64'h0123_4567_89AB_CDEF;
      expect_write(1'b1, 5'd25, 64'h0123_4567_89AB_CDEF);
      @(negedge clk);
      idle_inputs();
      check_out("b2b_ld", 1'b1);
      @(negedge clk);
      check("b2b_writes", 64'(wr_pulses - w0), 64'd4);
      check("b2b_ready_low", 64'(ready_low - r0), 64'd4);
    end

    // Reset during WAIT_MEM discards the load; a later rvalid is ignored.
    @(negedge clk);
    drive_op(1'b1, 5'd6, 64'h0, 1'b1, 3'b011, 3'd0);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    model_addr = '0; model_data = '0;
    check_out("midrst", 1'b0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    rvalid = 1'b1; rdata = R;
    @(negedge clk);
    idle_inputs();
    check_out("midrst_rvalid", 1'b0);
    check("midrst_ready", {63'd0, ready}, 64'd1);

`ifdef WB_LD_TIMEOUT_EN
    // 16 cycles without rvalid: timeout pulse and no write.
    @(negedge clk);
    drive_op(1'b1, 5'd4, 64'h0, 1'b1, 3'b011, 3'd0);
    @(negedge clk);
    idle_inputs();
    for (int k = 0; k < 15; k++) begin
      check("to_early", {63'd0, timeout}, 64'd0);
      @(negedge clk);
    end
    @(negedge clk);
    check("to_pulse", {63'd0, timeout}, 64'd1);
    check_out("to", 1'b0);
    check("to_ready", {63'd0, ready}, 64'd1);
    @(negedge clk);
    check("to_pulse_end", {63'd0, timeout}, 64'd0);
    // rvalid on the timeout cycle wins.
    drive_op(1'b1, 5'd4, 64'h0, 1'b1, 3'b011, 3'd0);
    @(negedge clk);
    idle_inputs();
    repeat (15) @(negedge clk);
    rvalid = 1'b1; rdata = 64'h55;
    expect_write(1'b1, 5'd4, 64'h55);
    @(negedge clk);
    idle_inputs();
    check_out("to_race", 1'b1);
    check("to_race_timeout", {63'd0, timeout}, 64'd0);
`endif

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
